// File: rtl/module_split_deserializer.sv
// Split-stage deserializer: packs sampled data bits LSB-first into words,
// accumulates the parity of the sampled state bits for each word, and hands
// completed or flushed words to a 2-entry valid/ready output buffer.
module module_split_deserializer #(
    parameter  int WIDTH_DS = 8,
    localparam int CNT_W_DS = $clog2(WIDTH_DS + 1)
) (
    input  logic                clock_ds,
    input  logic                reset_n_ds,
    input  logic                enable_ds,
    input  logic                data_bit_ds,
    input  logic                state_bit_ds,
    input  logic                flush_ds,
    input  logic                ready_in_ds,
    output logic                valid_out_ds,
    output logic [WIDTH_DS-1:0] word_out_ds,
    output logic [CNT_W_DS-1:0] count_out_ds,
    output logic                parity_out_ds,
    output logic                overflow_ds,
    output logic                busy_ds
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH_DS-1:0]   shift_q, shift_d;
    logic [CNT_W_DS-1:0]   cnt_q, cnt_d;
    logic                  par_q, par_d;

    logic [WIDTH_DS-1:0]   buf_word_q [2];
    logic [CNT_W_DS-1:0]   buf_cnt_q  [2];
    logic                  buf_par_q  [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            occ_q, occ_d;
    logic                  overflow_q;
    logic                  busy_q;

    logic [WIDTH_DS-1:0]   cap_shift;
    logic [CNT_W_DS-1:0]   cap_cnt;
    logic                  cap_par;
    logic                  emit, pop, accept;

    // Capture the current bit (if enabled), then decide whether a word leaves
    // the collector this edge and whether the buffer can take it.
    always_comb begin
        cap_shift = shift_q;
        cap_cnt   = cnt_q;
        cap_par   = par_q;
        if (enable_ds) begin
            for (int unsigned i = 0; i < WIDTH_DS; i++) begin
                if (CNT_W_DS'(i) == cnt_q) begin
                    cap_shift[i] = data_bit_ds;
                end
            end
            cap_cnt = cnt_q + CNT_W_DS'(1);
            cap_par = par_q ^ state_bit_ds;
        end

        // Completion and flush on the same edge fold into a single emit.
        emit   = (cap_cnt == CNT_W_DS'(WIDTH_DS)) | (flush_ds & (cap_cnt != '0));
        pop    = (occ_q != 2'd0) & ready_in_ds;
        accept = emit & ((occ_q != 2'd2) | pop);

        if (emit) begin
            shift_d = '0;
            cnt_d   = '0;
            par_d   = 1'b0;
        end else begin
            shift_d = cap_shift;
            cnt_d   = cap_cnt;
            par_d   = cap_par;
        end
        state_d = (cnt_d == '0) ? IDLE : COLLECT;

        case ({accept, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Collector, output buffer, sticky overflow and registered busy flag.
    always_ff @(posedge clock_ds or negedge reset_n_ds) begin
        if (!reset_n_ds) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            par_q      <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                buf_word_q[i] <= '0;
                buf_cnt_q[i]  <= '0;
                buf_par_q[i]  <= 1'b0;
            end
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            if (accept) begin
                buf_word_q[wr_ptr_q] <= cap_shift;
                buf_cnt_q[wr_ptr_q]  <= cap_cnt;
                buf_par_q[wr_ptr_q]  <= cap_par;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
            if (emit && !accept) begin
                overflow_q <= 1'b1;
            end
            busy_q <= (state_d == COLLECT) | (occ_d != 2'd0);
        end
    end

    // Head of the buffer, forced to zero while the buffer is empty.
    always_comb begin
        valid_out_ds  = (occ_q != 2'd0);
        word_out_ds   = valid_out_ds ? buf_word_q[rd_ptr_q] : '0;
        count_out_ds  = valid_out_ds ? buf_cnt_q[rd_ptr_q]  : '0;
        parity_out_ds = valid_out_ds ? buf_par_q[rd_ptr_q]  : 1'b0;
        overflow_ds   = overflow_q;
        busy_ds       = busy_q;
    end

endmodule

// File: tb/tb_module_split_deserializer.sv
// Scoreboard bench for module_split_deserializer: stimulus pushes hand-computed
// expected words into a queue; a negedge monitor pops and compares each word
// the DUT hands over.
module tb_module_split_deserializer;

    localparam int W = 8;
    localparam int CW = $clog2(W + 1);

    typedef struct packed {
        logic [W-1:0]  word;
        logic [CW-1:0] cnt;
        logic          par;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          din = 1'b0;
    logic          sin = 1'b0;
    logic          flush = 1'b0;
    logic          ready = 1'b0;
    logic          valid;
    logic [W-1:0]  word;
    logic [CW-1:0] cnt;
    logic          par;
    logic          ovf;
    logic          busy;

    int compared = 0;
    int mismatched = 0;
    exp_t exp_q[$];

    module_split_deserializer #(.WIDTH_DS(W)) dut (
        .clock_ds      (clk),
        .reset_n_ds    (rst_n),
        .enable_ds     (en),
        .data_bit_ds   (din),
        .state_bit_ds  (sin),
        .flush_ds      (flush),
        .ready_in_ds   (ready),
        .valid_out_ds  (valid),
        .word_out_ds   (word),
        .count_out_ds  (cnt),
        .parity_out_ds (par),
        .overflow_ds   (ovf),
        .busy_ds       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake seen at the negedge is consumed at the next posedge.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_word: got word 0x%0h cnt %0d, none expected", word, cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("word", 32'(word), 32'(e.word));
                chk("count", 32'(cnt), 32'(e.cnt));
                chk("parity", 32'(par), 32'(e.par));
            end
        end
    end

    task automatic step(input logic e, input logic d, input logic s, input logic f);
        en = e; din = d; sin = s; flush = f;
        @(posedge clk); #1;
        en = 1'b0; flush = 1'b0; din = 1'b0; sin = 1'b0;
    endtask

    task automatic expect_word(input logic [W-1:0] w, input int c, input logic p);
        exp_t e;
        e.word = w; e.cnt = CW'(c); e.par = p;
        exp_q.push_back(e);
    endtask

    // Sends nbits bits of data/state LSB-first; flush raised on the last bit if f.
    task automatic send(input logic [W-1:0] d, input logic [W-1:0] s, input int nbits, input logic f);
        for (int i = 0; i < nbits; i++) begin
            step(1'b1, d[i], s[i], f && (i == nbits - 1));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_word", 32'(word), 0);
        chk("rst_count", 32'(cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(ovf), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // 1: full word 0x4D, parity of eight ones = 0, one-cycle visibility
        ready = 1'b1;
        expect_word(8'h4D, 8, 1'b0);
        send(8'h4D, 8'hFF, 8, 1'b0);
        chk("t1_valid", 32'(valid), 1);
        chk("t1_busy", 32'(busy), 1);
        idle(1);
        chk("t1_valid_gone", 32'(valid), 0);
        chk("t1_busy_drop", 32'(busy), 0);

        // 2: three bits then flush without enable
        send(8'h03, 8'h01, 3, 1'b0);
        chk("t2_busy_collect", 32'(busy), 1);
        chk("t2_no_valid", 32'(valid), 0);
        expect_word(8'h03, 3, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_valid", 32'(valid), 1);
        idle(2);
        // flush with nothing collected does nothing
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_empty_flush", 32'(valid), 0);

        // 3: stalled output, third word dropped
        ready = 1'b0;
        expect_word(8'hFF, 8, 1'b0);
        expect_word(8'hFF, 8, 1'b0);
        send(8'hFF, 8'h00, 8, 1'b0);
        send(8'hFF, 8'h00, 8, 1'b0);
        chk("t3_valid", 32'(valid), 1);
        chk("t3_no_ovf_yet", 32'(ovf), 0);
        send(8'hFF, 8'h00, 8, 1'b0);
        chk("t3_ovf", 32'(ovf), 1);
        ready = 1'b1;
        idle(2);
        chk("t3_drained", 32'(valid), 0);
        chk("t3_ovf_sticky", 32'(ovf), 1);

        // 4: flush on the completing bit gives exactly one word
        expect_word(8'hC3, 8, 1'b0);
        send(8'hC3, 8'hFF, 8, 1'b1);
        chk("t4_count_head", 32'(cnt), 8);
        idle(3);
        chk("t4_single", 32'(valid), 0);

        // 5: asynchronous reset mid-word
        send(8'h1F, 8'h00, 5, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(valid), 0);
        chk("t5_word", 32'(word), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_ovf_cleared", 32'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_word(8'hA5, 8, 1'b1);
        send(8'hA5, 8'h01, 8, 1'b0);
        idle(2);

        // 6: full buffer, completion coincides with a pop
        ready = 1'b0;
        expect_word(8'h11, 8, 1'b1);
        expect_word(8'h22, 8, 1'b0);
        expect_word(8'h33, 8, 1'b1);
        send(8'h11, 8'h80, 8, 1'b0);
        send(8'h22, 8'h00, 8, 1'b0);
        send(8'h33, 8'h10, 7, 1'b0);
        ready = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t6_no_ovf", 32'(ovf), 0);
        chk("t6_full", 32'(valid), 1);
        idle(3);
        chk("t6_drained", 32'(valid), 0);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/module_split_deserializer.md
Name: module_split_deserializer

Overview:
- Downstream consumer of the split-variable combinational stage.
- Samples that stage's per-cycle data bit (data_split) and state bit (state) whenever the shared enable is high.
- Packs the data bits LSB-first into words and accumulates state-bit parity per word.
- Hands complete or flushed words to the next stage through a 2-entry valid/ready output buffer.

Parameters:
- WIDTH_DS, 8, word width in bits; legal range 2..32.
- CNT_W_DS, $clog2(WIDTH_DS+1), width of the bit-count field (derived; not overridden).

Ports:
- clock_ds  in  1  sole clock; all state updates on rising edge
- reset_n_ds  in  1  asynchronous, active-low reset
- enable_ds  in  1  sample strobe; same enable that drives the upstream stage
- data_bit_ds  in  1  upstream data_split bit 0 output
- state_bit_ds  in  1  upstream state output
- flush_ds  in  1  emit the partial word at this edge
- ready_in_ds  in  1  downstream ready
- valid_out_ds  out  1  buffer head valid
- word_out_ds  out  WIDTH_DS  buffer head word; unfilled upper bits are zero
- count_out_ds  out  CNT_W_DS  number of valid bits in head word (1..WIDTH_DS)
- parity_out_ds  out  1  XOR of the state bits captured with head word
- overflow_ds  out  1  sticky: a completed word was dropped
- busy_ds  out  1  collecting a word, or buffer not empty

Behaviour:
- Reset (async assert, sync-safe deassert):
  - FSM=IDLE; shift register, bit count, parity accumulator, buffer pointers and occupancy all zero.
  - Outputs: valid_out_ds=0, word_out_ds=0, count_out_ds=0, parity_out_ds=0, overflow_ds=0, busy_ds=0.
  - Reset mid-word discards the partial word; no emit.
- FSM states: IDLE (count=0), COLLECT (0<count<WIDTH_DS).
  - IDLE -> COLLECT on enable_ds=1 without completion or flush.
  - COLLECT -> IDLE on word completion or flush.
- Capture on an enable_ds=1 edge:
  - shift[count] <= data_bit_ds
  - parity_acc <= parity_acc ^ state_bit_ds
  - count <= count+1
- Completion: the capture that makes count==WIDTH_DS emits {word, WIDTH_DS, parity} and clears count/shift/parity the same edge.
- Flush (flush_ds=1) at the edge:
  - With count>0, emits the partial word, zero-padded, with count_out=count.
  - If enable_ds is also 1, the current bit is included first (count+1).
  - Flush that coincides with completion produces exactly one emit.
  - Flush with count=0 and enable_ds=0 does nothing.
- Emit latency: a word emitted at edge N is visible on the outputs after edge N (valid_out_ds=1 in cycle N+1) when the buffer was empty. No combinational path from inputs to outputs.
- Output buffer: 2 entries, FIFO order; head drives word/count/parity outputs.
  - valid_out_ds = occupancy!=0.
  - Pop when valid_out_ds & ready_in_ds.
  - Push is accepted if occupancy<2 or a pop occurs the same edge. Simultaneous push+pop at occupancy 2 keeps occupancy 2.
  - Push refused when full with no pop: the word is dropped and overflow_ds is set to 1. It stays 1 until reset.
  - Collection never stalls; enable_ds is always honoured.
  - When valid_out_ds=0, word/count/parity outputs are zero.
- busy_ds = (FSM==COLLECT) | (occupancy!=0), registered.
- Pointers wrap modulo 2; occupancy never exceeds 2 or underflows. Pop with occupancy 0 is impossible because it is gated by valid.

Test Plan:
1. WIDTH_DS=8, ready=1, 8 consecutive enabled bits data=1,0,1,1,0,0,1,0 (first bit first), state=1 each -> next cycle valid=1, word=0x4D, count=8, parity=0, for one cycle; busy drops after the pop.
2. Enable 3 bits data=1,1,0, state=1,0,0, then flush_ds=1 with enable=0 -> word=0x03, count=3, parity=1.
3. ready=0, 24 enabled bits of data=1 -> after bit 16, valid=1 with 2 words of 0xFF queued. On bit 24, overflow_ds=1 and the third word is dropped. Then ready=1 -> two 0xFF words in two cycles, then valid=0; overflow_ds remains 1.
4. 7 enabled bits, then on the 8th enabled bit also assert flush_ds -> exactly one word, count=8; no second (empty) word.
5. 5 enabled bits, assert reset_n_ds=0 asynchronously mid-cycle -> all outputs 0 immediately. After release, 8 bits data=0xA5 LSB-first -> word=0xA5, count=8, no trace of the discarded bits.
6. Buffer full (ready=0, 2 words), complete a third word on the same edge that ready=1 pops -> no overflow; the three words exit in order.
